// File: rtl/matmul_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_sequencer
//
// Controller and accumulator for an N x N unsigned matrix multiplier that
// computes C = A x B.  Operands live in two external synchronous-read
// memories; results are written to an external result memory.
//
// Run timeline (cycle 0 is the clock edge that samples start in IDLE):
//   cycles 1 .. N^3      one A/B read issued per cycle (ISSUE)
//   cycle  n+1           read data for issue n arrives, product accumulated
//   cycle  n+2           C write strobe when issue n was the last inner step
//   cycles N^3+1, N^3+2  DRAIN (last accumulate, last write)
//   cycle  N^3+3         done pulse (DONE), then back to IDLE
//
// Ports:
//   clock   in   1     system clock, rising edge
//   reset   in   1     asynchronous active-low reset
//   start   in   1     request a multiply (sampled in IDLE only)
//   a_addr  out  AW    A read address, i*N+k (0 outside ISSUE)
//   b_addr  out  AW    B read address, k*N+j (0 outside ISSUE)
//   a_data  in   DW    A read data, one cycle after a_addr
//   b_data  in   DW    B read data, one cycle after b_addr
//   c_we    out  1     result write strobe, one cycle per C entry
//   c_addr  out  AW    result address i*N+j
//   c_data  out  ACCW  result value
//   busy    out  1     high while a multiply is in progress
//   done    out  1     one-cycle pulse after the final C write
// ---------------------------------------------------------------------------
module matmul_sequencer #(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int AW   = 2,
  parameter int ACCW = 17
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic [AW-1:0]   a_addr,
  output logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   a_data,
  input  logic [DW-1:0]   b_data,
  output logic            c_we,
  output logic [AW-1:0]   c_addr,
  output logic [ACCW-1:0] c_data,
  output logic            busy,
  output logic            done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Loop counters describe the read being issued in the current cycle.
  logic [CW-1:0] i_reg, j_reg, k_reg;
  logic [CW-1:0] i_next, j_next, k_next;
  logic          last_issue;
  logic          drain_reg;

  // One-cycle delayed copy of the issue, aligned with the returning data.
  logic          d_valid_reg;
  logic [CW-1:0] d_i_reg, d_j_reg, d_k_reg;

  logic [ACCW-1:0] acc_reg;
  logic [ACCW-1:0] product;
  logic [ACCW-1:0] acc_next;

  logic [AW-1:0]   a_addr_reg, b_addr_reg;
  logic            c_we_reg;
  logic [AW-1:0]   c_addr_reg;
  logic [ACCW-1:0] c_data_reg;

  function automatic logic [AW-1:0] lin(input logic [CW-1:0] row,
                                        input logic [CW-1:0] col);
    lin = AW'(int'(row) * N + int'(col));
  endfunction

  assign last_issue = (i_reg == LAST) && (j_reg == LAST) && (k_reg == LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (last_issue) state_next = DRAIN;
      DRAIN:   if (drain_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs decoded from the state register
  // -------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      ISSUE:   busy = 1'b1;
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Counter sequencing: k innermost, then j, then i.
  // -------------------------------------------------------------------------
  always_comb begin
    i_next = i_reg;
    j_next = j_reg;
    k_next = k_reg;
    if (state_reg == IDLE) begin
      if (start) begin
        i_next = '0;
        j_next = '0;
        k_next = '0;
      end
    end else if (state_reg == ISSUE) begin
      if (k_reg == LAST) begin
        k_next = '0;
        if (j_reg == LAST) begin
          j_next = '0;
          i_next = (i_reg == LAST) ? '0 : i_reg + 1'b1;
        end else begin
          j_next = j_reg + 1'b1;
        end
      end else begin
        k_next = k_reg + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Accumulator: the first inner step of each C entry loads, others add.
  // -------------------------------------------------------------------------
  assign product  = ACCW'(a_data) * ACCW'(b_data);
  assign acc_next = (d_k_reg == '0) ? product : acc_reg + product;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_reg       <= '0;
      j_reg       <= '0;
      k_reg       <= '0;
      drain_reg   <= 1'b0;
      a_addr_reg  <= '0;
      b_addr_reg  <= '0;
      d_valid_reg <= 1'b0;
      d_i_reg     <= '0;
      d_j_reg     <= '0;
      d_k_reg     <= '0;
      acc_reg     <= '0;
      c_we_reg    <= 1'b0;
      c_addr_reg  <= '0;
      c_data_reg  <= '0;
    end else begin
      i_reg <= i_next;
      j_reg <= j_next;
      k_reg <= k_next;

      // Two DRAIN cycles: drain_reg is 0 in the first and 1 in the second.
      drain_reg <= (state_reg == DRAIN) ? ~drain_reg : 1'b0;

      // Addresses are registered from the next-cycle counters so they are
      // valid for the whole issue cycle and return to 0 outside ISSUE.
      if (state_next == ISSUE) begin
        a_addr_reg <= lin(i_next, k_next);
        b_addr_reg <= lin(k_next, j_next);
      end else begin
        a_addr_reg <= '0;
        b_addr_reg <= '0;
      end

      d_valid_reg <= (state_reg == ISSUE);
      d_i_reg     <= i_reg;
      d_j_reg     <= j_reg;
      d_k_reg     <= k_reg;

      if (d_valid_reg) begin
        acc_reg <= acc_next;
      end

      // The write follows the capture of the last inner product; c_data
      // takes the freshly accumulated sum at the same edge.
      c_we_reg <= d_valid_reg && (d_k_reg == LAST);
      if (d_valid_reg && (d_k_reg == LAST)) begin
        c_addr_reg <= lin(d_i_reg, d_j_reg);
        c_data_reg <= acc_next;
      end
    end
  end

  assign a_addr = a_addr_reg;
  assign b_addr = b_addr_reg;
  assign c_we   = c_we_reg;
  assign c_addr = c_addr_reg;
  assign c_data = c_data_reg;

endmodule

// File: tb/tb_matmul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matmul_sequencer
//
// Directed bench for matmul_sequencer with N=2. Synchronous-read A/B
// memories are modelled here; expected products are hand computed.
// ---------------------------------------------------------------------------
module tb_matmul_sequencer;

  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int ACCW = 17;

  logic            clock;
  logic            reset;
  logic            start;
  logic [AW-1:0]   a_addr;
  logic [AW-1:0]   b_addr;
  logic [DW-1:0]   a_data;
  logic [DW-1:0]   b_data;
  logic            c_we;
  logic [AW-1:0]   c_addr;
  logic [ACCW-1:0] c_data;
  logic            busy;
  logic            done;

  logic [DW-1:0]   amem [4];
  logic [DW-1:0]   bmem [4];
  logic [ACCW-1:0] cexp [4];

  int compared;
  int mismatched;

  matmul_sequencer #(.N(N), .DW(DW), .AW(AW), .ACCW(ACCW)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .a_addr (a_addr),
    .b_addr (b_addr),
    .a_data (a_data),
    .b_data (b_data),
    .c_we   (c_we),
    .c_addr (c_addr),
    .c_data (c_data),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read operand memories: data one cycle after address.
  always @(posedge clock) begin
    a_data <= amem[a_addr];
    b_data <= bmem[b_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic load(input logic [DW-1:0] a0, a1, a2, a3,
                      input logic [DW-1:0] b0, b1, b2, b3,
                      input logic [ACCW-1:0] c0, c1, c2, c3);
    amem[0] = a0; amem[1] = a1; amem[2] = a2; amem[3] = a3;
    bmem[0] = b0; bmem[1] = b1; bmem[2] = b2; bmem[3] = b3;
    cexp[0] = c0; cexp[1] = c1; cexp[2] = c2; cexp[3] = c3;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".a_addr"}, 32'(a_addr), 0);
    chk({tag, ".b_addr"}, 32'(b_addr), 0);
    chk({tag, ".c_we"},   32'(c_we),   0);
    chk({tag, ".c_addr"}, 32'(c_addr), 0);
    chk({tag, ".c_data"}, 32'(c_data), 0);
    chk({tag, ".busy"},   32'(busy),   0);
    chk({tag, ".done"},   32'(done),   0);
  endtask

  // One run with cycle-exact checks. smask bit c drives start during cycle c
  // (bit 0 is the cycle before the sampling edge).
  task automatic run_single(input string tag, input int ncyc, input logic [39:0] smask);
    int nw, nd, n, ea, eb, widx;
    nw = 0;
    nd = 0;
    @(negedge clock);
    start = smask[0];
    @(posedge clock);
    #1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      start = smask[cyc];
      ea = 0;
      eb = 0;
      if (cyc <= 8) begin
        n  = cyc - 1;
        ea = (n / 4) * 2 + (n % 2);          // i*N+k
        eb = (n % 2) * 2 + ((n / 2) % 2);    // k*N+j
      end
      chk($sformatf("%s.a_addr@%0d", tag, cyc), 32'(a_addr), 32'(ea));
      chk($sformatf("%s.b_addr@%0d", tag, cyc), 32'(b_addr), 32'(eb));
      chk($sformatf("%s.busy@%0d", tag, cyc), 32'(busy), 32'(cyc <= 10));
      chk($sformatf("%s.done@%0d", tag, cyc), 32'(done), 32'(cyc == 11));
      chk($sformatf("%s.c_we@%0d", tag, cyc), 32'(c_we),
          32'(cyc >= 4 && cyc <= 10 && (cyc % 2) == 0));
      if (c_we === 1'b1) begin
        nw++;
        widx = (cyc - 4) / 2;
        $display("%s write cycle=%0d addr=%0d data=%0d", tag, cyc, c_addr, c_data);
        if (widx >= 0 && widx < 4) begin
          chk($sformatf("%s.c_addr@%0d", tag, cyc), 32'(c_addr), 32'(widx));
          chk($sformatf("%s.c_data@%0d", tag, cyc), 32'(c_data), 32'(cexp[widx]));
        end
      end
      if (done === 1'b1) nd++;
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    chk({tag, ".writes"}, 32'(nw), 4);
    chk({tag, ".dones"}, 32'(nd), 1);
  endtask

  initial begin
    int nw, nd, d1, d2, widx;
    compared   = 0;
    mismatched = 0;
    start      = 1'b0;
    reset      = 1'b0;
    load(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Identity x B
    load(8'd1, 8'd0, 8'd0, 8'd1, 8'd5, 8'd6, 8'd7, 8'd8, 5, 6, 7, 8);
    run_single("ident", 14, 40'h1);

    // General product
    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 19, 22, 43, 50);
    run_single("general", 14, 40'h1);

    // Width corner
    load(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
         130050, 130050, 130050, 130050);
    run_single("wide", 14, 40'h1);

    // start re-asserted in cycles 3 and 11: ignored, no second run
    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 19, 22, 43, 50);
    run_single("restart", 18, 40'h1 | (40'h1 << 3) | (40'h1 << 11));

    // Asynchronous reset in the middle of cycle 5
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);  // now at the start of cycle 5
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    nw = 0;
    nd = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clock);
      #1;
      if (c_we === 1'b1) nw++;
      if (done === 1'b1) nd++;
    end
    chk("midreset.writes_after", 32'(nw), 0);
    chk("midreset.dones_after", 32'(nd), 0);
    chk("midreset.busy_after", 32'(busy), 0);
    run_single("postreset", 14, 40'h1);

    // start held high: two back-to-back runs, one idle cycle between them
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    nw = 0;
    nd = 0;
    d1 = 0;
    d2 = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      start = (cyc <= 23);
      if (c_we === 1'b1) begin
        widx = nw % 4;
        $display("held write cycle=%0d addr=%0d data=%0d", cyc, c_addr, c_data);
        chk($sformatf("held.c_addr@%0d", cyc), 32'(c_addr), 32'(widx));
        chk($sformatf("held.c_data@%0d", cyc), 32'(c_data), 32'(cexp[widx]));
        nw++;
      end
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) d1 = cyc;
        if (nd == 2) d2 = cyc;
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    chk("held.writes", 32'(nw), 8);
    chk("held.dones", 32'(nd), 2);
    chk("held.done1_cycle", 32'(d1), 11);
    chk("held.done2_cycle", 32'(d2), 23);
    chk("held.busy_end", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", compared);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Controller and accumulator for the matrix multiplier. It computes C = A x B for N x N unsigned matrices held in two external operand memories. It issues A and B read addresses in row-column-inner order, accumulates the inner products internally, and writes each C entry to the result memory. It also handles the start/busy/done handshake for the top level.

Parameters:
N, 2, matrix dimension (N >= 2)
DW, 8, operand data width
AW, 2, address width; must satisfy 2^AW >= N*N
ACCW, 17, accumulator/result width; must be >= 2*DW + ceil(log2 N)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request a multiply; sampled only in IDLE
a_addr  out  AW  A memory read address (row-major, i*N+k)
b_addr  out  AW  B memory read address (row-major, k*N+j)
a_data  in  DW  A read data, valid one cycle after a_addr
b_data  in  DW  B read data, valid one cycle after b_addr
c_we  out  1  result write strobe, one cycle per C entry
c_addr  out  AW  result write address (i*N+j)
c_data  out  ACCW  result value
busy  out  1  high while a multiply is in progress
done  out  1  one-cycle pulse after the final C write

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, i=j=k=0, accumulator=0, pipeline valid=0.
  - All outputs 0: a_addr, b_addr, c_we, c_addr, c_data, busy, done.
  - Reset takes effect immediately, mid-operation included. The run is abandoned, no further c_we is issued, and no done pulse follows.
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: when start=1 at a clock edge, go to ISSUE. Clear i, j, k.
  - ISSUE: one read issued per cycle. Drive a_addr=i*N+k and b_addr=k*N+j, all registered.
    - Advance k. On k wrap, advance j. On j wrap, advance i.
    - After the issue with i=j=k=N-1, go to DRAIN.
  - DRAIN: 2 cycles, completing the last accumulate and the last write. Then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Issue and accumulate timing:
  - Issue n (n = 1..N^3) occurs in cycle n after the start edge.
  - A delayed valid/k/i/j copy tracks each issue by one cycle. The product a_data*b_data, widened to ACCW, is captured at the end of cycle n+1.
  - When the delayed k = 0, the accumulator loads the product; otherwise it adds the product.
- Write timing:
  - Following a capture with delayed k = N-1, c_we=1 in the next cycle (cycle n+2).
  - In that cycle c_addr = delayed i*N + delayed j and c_data = the accumulator.
  - c_we is high for one cycle per entry, giving N^2 writes per run in ascending c_addr order.
- busy is high in cycles 1 .. N^3+2. done is high in cycle N^3+3. For N=2: 8 issues, writes in cycles 4, 6, 8, 10, and done in cycle 11.
- Idle outputs: a_addr and b_addr hold 0 outside ISSUE. c_addr and c_data hold their last value when c_we=0 and are not checked.
- Arithmetic: unsigned only. With the ACCW constraint met there is no overflow. If ACCW is undersized, results wrap modulo 2^ACCW with no flag.
- start while busy or in DONE is ignored and not queued.
- start held high continuously: DONE -> IDLE, then the next run is accepted from IDLE. One idle cycle separates runs.

Test Plan:
- Identity x B, N=2: A=[1,0,0,1], B=[5,6,7,8], start pulsed -> writes (addr,data) = (0,5), (1,6), (2,7), (3,8) in cycles 4, 6, 8, 10; done pulse in cycle 11; busy high in cycles 1-10.
- General product: A=[1,2,3,4], B=[5,6,7,8] -> C = 19, 22, 43, 50 at c_addr 0-3; a_addr/b_addr sequence (0,0), (1,2), (0,1), (1,3), (2,0), (3,2), (2,1), (3,3).
- Width corner: all operands 255 -> every c_data = 130050 (fits in 17 bits); exactly 4 c_we pulses.
- start re-asserted in cycles 3 and 11 -> ignored; exactly one run (4 writes, 1 done); no new busy after done until start is sampled in IDLE.
- reset driven low asynchronously mid-cycle 5 -> all outputs 0 immediately; no further c_we and no done; after release, a start produces a full correct run.
- start held high for 30 cycles -> two back-to-back complete runs with 4 writes each, done pulses 12 cycles apart (one idle cycle between runs).
